// File: rtl/lc3b_types.sv
// Shared LC-3b types for the pipeline memory path.
// Word, write-mask and memory arbiter state definitions.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_DONE,
    D_DONE
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory handshake bundle between fetch/MEM requesters,
// the arbiter, and the physical memory port.
// slave  : arbiter view (requests in, responses and pmem strobes out)
// master : environment view (datapath + memory model)
interface mem_arbiter_if;
  import lc3b_types::*;

  lc3b_word      i_mem_address;
  logic          i_mem_read;
  lc3b_word      i_mem_rdata;
  logic          i_mem_resp;

  lc3b_word      d_mem_address;
  logic          d_mem_read;
  logic          d_mem_write;
  lc3b_mem_wmask d_mem_byte_enable;
  lc3b_word      d_mem_wdata;
  lc3b_word      d_mem_rdata;
  logic          d_mem_resp;

  lc3b_word      pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  lc3b_mem_wmask pmem_byte_enable;
  lc3b_word      pmem_wdata;
  lc3b_word      pmem_rdata;
  logic          pmem_resp;

  modport slave (
    input  i_mem_address, i_mem_read,
    output i_mem_rdata, i_mem_resp,
    input  d_mem_address, d_mem_read, d_mem_write,
    input  d_mem_byte_enable, d_mem_wdata,
    output d_mem_rdata, d_mem_resp,
    output pmem_address, pmem_read, pmem_write,
    output pmem_byte_enable, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_mem_address, i_mem_read,
    input  i_mem_rdata, i_mem_resp,
    output d_mem_address, d_mem_read, d_mem_write,
    output d_mem_byte_enable, d_mem_wdata,
    input  d_mem_rdata, d_mem_resp,
    input  pmem_address, pmem_read, pmem_write,
    input  pmem_byte_enable, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/mem_arb_perf.sv
// Arbiter performance counters (built only with MEM_ARB_PERF_EN).
// Ports: clk, rst, grant/conflict strobes in; three 32-bit wrapping counts out.
module mem_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_grant_i,
  input  logic        d_grant_i,
  input  logic        conflict_i,
  output logic [31:0] i_grants_o,
  output logic [31:0] d_grants_o,
  output logic [31:0] conflicts_o
);

  logic [31:0] i_cnt_q, i_cnt_d;
  logic [31:0] d_cnt_q, d_cnt_d;
  logic [31:0] c_cnt_q, c_cnt_d;

  always_comb begin
    i_cnt_d = i_cnt_q + {31'd0, i_grant_i};
    d_cnt_d = d_cnt_q + {31'd0, d_grant_i};
    c_cnt_d = c_cnt_q + {31'd0, conflict_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
      c_cnt_q <= c_cnt_d;
    end
  end

  assign i_grants_o  = i_cnt_q;
  assign d_grants_o  = d_cnt_q;
  assign conflicts_o = c_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data memory arbiter onto one registered physical port.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.slave).
// With MEM_ARB_PERF_EN defined: perf_i_grants, perf_d_grants,
// perf_conflict_cycles (32-bit counters from mem_arb_perf).
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_conflict_cycles
`endif
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  arb_state_t    state_q;
  logic [CW-1:0] starve_q;
  logic          abort_q;
  lc3b_word      addr_q;
  lc3b_word      wdata_q;
  lc3b_mem_wmask be_q;
  logic          rd_q;
  logic          wr_q;
  lc3b_word      i_rdata_q;
  lc3b_word      d_rdata_q;
  logic          i_resp_q;
  logic          d_resp_q;

  logic i_pend;
  logic d_pend;
  logic i_grant;
  logic d_grant;
  logic i_abort;

  assign i_pend = bus.i_mem_read;
  assign d_pend = bus.d_mem_read | bus.d_mem_write;

  // D normally wins; once it has taken STARVE_LIMIT grants
  // over a waiting fetch, the fetch gets the next slot.
  always_comb begin
    i_grant = 1'b0;
    d_grant = 1'b0;
    if (state_q == IDLE) begin
      if (d_pend && (starve_q < LIM))
        d_grant = 1'b1;
      else if (i_pend)
        i_grant = 1'b1;
      else if (d_pend)
        d_grant = 1'b1;
    end
  end

  // A withdrawn or redirected fetch still lets pmem finish,
  // but its data must not reach the pipeline.
  assign i_abort = abort_q
                 | ~bus.i_mem_read
                 | (bus.i_mem_address != addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      abort_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!i_pend)
            starve_q <= '0;
          if (i_grant) begin
            state_q  <= I_BUSY;
            addr_q   <= bus.i_mem_address;
            rd_q     <= 1'b1;
            abort_q  <= 1'b0;
            starve_q <= '0;
          end else if (d_grant) begin
            state_q <= D_BUSY;
            addr_q  <= bus.d_mem_address;
            wdata_q <= bus.d_mem_wdata;
            be_q    <= bus.d_mem_byte_enable;
            rd_q    <= bus.d_mem_read;
            wr_q    <= bus.d_mem_write;
            if (i_pend && (starve_q != LIM))
              starve_q <= starve_q + CW'(1);
          end
        end
        I_BUSY: begin
          if (i_abort)
            abort_q <= 1'b1;
          if (bus.pmem_resp) begin
            rd_q    <= 1'b0;
            abort_q <= 1'b0;
            if (i_abort) begin
              state_q <= IDLE;
            end else begin
              state_q   <= I_DONE;
              i_rdata_q <= bus.pmem_rdata;
              i_resp_q  <= 1'b1;
            end
          end
        end
        D_BUSY: begin
          if (bus.pmem_resp) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            state_q   <= D_DONE;
            d_rdata_q <= bus.pmem_rdata;
            d_resp_q  <= 1'b1;
          end
        end
        I_DONE: state_q <= IDLE;
        D_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pmem_address     = addr_q;
  assign bus.pmem_read        = rd_q;
  assign bus.pmem_write       = wr_q;
  assign bus.pmem_byte_enable = be_q;
  assign bus.pmem_wdata       = wdata_q;
  assign bus.i_mem_rdata      = i_rdata_q;
  assign bus.i_mem_resp       = i_resp_q;
  assign bus.d_mem_rdata      = d_rdata_q;
  assign bus.d_mem_resp       = d_resp_q;

`ifdef MEM_ARB_PERF_EN
  logic conflict;
  assign conflict = (state_q == IDLE) & i_pend & d_pend;

  mem_arb_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_grant_i   (i_grant),
    .d_grant_i   (d_grant),
    .conflict_i  (conflict),
    .i_grants_o  (perf_i_grants),
    .d_grants_o  (perf_d_grants),
    .conflicts_o (perf_conflict_cycles)
  );
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the pipeline memory handshake: services the fetch stage's i_mem_read and the MEM stage's d_mem_read/d_mem_write.
- Returns single-cycle i_mem_resp/d_mem_resp pulses, which the hazard unit consumes to advance the pipeline.
- Arbitrates both requesters onto one physical word-wide memory port (pmem_*) with registered outputs.
- Sits between the datapath and the memory model or L2.

Parameters:
STARVE_LIMIT, 4, consecutive D grants allowed while an I request waits; after that, I wins the next arbitration (minimum 1).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_mem_address  in  16  fetch address (lc3b_word)
i_mem_read  in  1  fetch request; level, held until i_mem_resp or withdrawn
i_mem_rdata  out  16  fetched word; valid when i_mem_resp=1
i_mem_resp  out  1  one-cycle completion pulse for fetch
d_mem_address  in  16  data address
d_mem_read  in  1  data read request; level
d_mem_write  in  1  data write request; level; mutually exclusive with d_mem_read
d_mem_byte_enable  in  2  write byte mask (lc3b_mem_wmask)
d_mem_wdata  in  16  write data
d_mem_rdata  out  16  read data; valid when d_mem_resp=1
d_mem_resp  out  1  one-cycle completion pulse for data
pmem_address  out  16  physical address, registered at grant
pmem_read  out  1  physical read strobe, held until pmem_resp
pmem_write  out  1  physical write strobe, held until pmem_resp
pmem_byte_enable  out  2  registered write mask
pmem_wdata  out  16  registered write data
pmem_rdata  in  16  physical read data; valid with pmem_resp
pmem_resp  in  1  physical completion, one cycle

Behaviour:
- FSM states: IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE.
- IDLE arbitration (evaluated every IDLE cycle):
  - D pending and starve_cnt < STARVE_LIMIT: D wins.
  - Otherwise, I pending: I wins.
  - Otherwise, D pending: D wins.
  - Nothing pending: stay in IDLE.
- Grant: register address, wdata and mask. Next cycle, pmem_read/pmem_write asserts and the FSM enters x_BUSY.
- x_BUSY: strobe held, address stable. On pmem_resp, capture pmem_rdata into x_mem_rdata and go to x_DONE.
- x_DONE: x_mem_resp=1 for exactly one cycle, then IDLE. x_mem_rdata holds its value until the next capture.
- Minimum latency: request in IDLE at cycle N gives pmem strobe at N+1. If pmem_resp arrives at N+1, x_mem_resp pulses at N+2.
- Back-to-back requests pass through one IDLE bubble.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - Increments on each D grant while i_mem_read=1.
  - Clears on each I grant, and whenever i_mem_read=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- I abort: in I_BUSY, if i_mem_read falls or i_mem_address differs from the latched address (branch redirect), set abort. The pmem transaction still completes. On pmem_resp the FSM goes directly to IDLE, with no i_mem_resp and no rdata update.
- D side is never aborted. A dropped D request still completes and still pulses d_mem_resp.
- Both x_mem_resp outputs are never high in the same cycle. pmem_read and pmem_write are never high together.
- pmem_resp outside x_BUSY is ignored.
- Reset (any state, including mid-transaction) → IDLE next edge; all outputs 0; starve_cnt=0; abort=0. The in-flight pmem transaction is abandoned; the memory model must tolerate this.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_i_grants, perf_d_grants and perf_conflict_cycles, each 32 bits.
  - perf_conflict_cycles counts IDLE cycles in which both requests are pending.
  - All three counters wrap at 2^32 and clear on rst.
- Undefined: these ports and counters do not exist; functional behaviour is identical.

Decomposition:
- lc3b_types gains:
  - lc3b_mem_wmask (logic [1:0]).
  - arb_state_t enum (IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE).
- The FSM, the latches and starve_cnt live in mem_arbiter.
- Counters under MEM_ARB_PERF_EN go in one sub-module, mem_arb_perf, instantiated only when the macro is defined.

Test Plan:
- I read 0x0040; pmem_resp after 3 cycles with rdata 0x1234 → pmem_read at N+1, addr 0x0040; i_mem_resp single pulse one cycle after pmem_resp, i_mem_rdata=0x1234.
- Same-cycle I read 0x0040 and D write 0x0100/0xBEEF/mask 2'b01 → pmem_write first with byte_enable 2'b01; d_mem_resp; one IDLE bubble; then pmem_read 0x0040.
- i_mem_read held; D requests continuous; STARVE_LIMIT=4 → exactly 4 D grants, then an I grant; starve_cnt back to 0.
- I granted; i_mem_address changes 0x0040→0x0080 during I_BUSY → no i_mem_resp for 0x0040; the next grant is I at 0x0080.
- rst asserted in D_BUSY → next cycle all outputs 0, FSM IDLE; pmem_resp one cycle later ignored, no d_mem_resp.
- MEM_ARB_PERF_EN defined, scenario 2 run → perf_i_grants=1, perf_d_grants=1, perf_conflict_cycles=1.
